// File: rtl/alu_seq_ctrl.sv
// Four-state (IDLE/READ/EXEC/WB) sequencer that feeds the 16-bit ALU from the register file and owns the PSR.
// Optional macro ALU_SEQ_PSR_LOAD_EN adds psr_we/psr_wdata for a direct PSR load that overrides writeback flags.
module alu_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        rf_raddr_a,
    output logic [3:0]        rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    output logic [3:0]        alu_opext,
    output logic              alu_carry,
    input  logic [DATA_W-1:0] alu_s,
    input  logic [FLAG_W-1:0] alu_clfzn,
`ifdef ALU_SEQ_PSR_LOAD_EN
    input  logic              psr_we,
    input  logic [FLAG_W-1:0] psr_wdata,
`endif
    output logic [FLAG_W-1:0] psr,
    output logic              done,
    output logic              illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [FLAG_W-1:0]   flg_q, flg_d;
    logic [FLAG_W-1:0]   psr_q, psr_d;
    logic                legal_q, legal_d;

    function automatic logic signed [DATA_W-1:0] sext_imm8(input logic signed [7:0] imm);
        return {{(DATA_W-8){imm[7]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zext_imm8(input logic [7:0] imm);
        return {{(DATA_W-8){1'b0}}, imm};
    endfunction

    // ADDI/ADDCI take a signed immediate, ADDUI an unsigned one; everything else reads rsrc.
    function automatic logic [DATA_W-1:0] operand_b(input logic [15:0] ins, input logic [DATA_W-1:0] rdata);
        case (ins[15:12])
            4'b0101, 4'b0111: return sext_imm8(ins[7:0]);
            4'b0110:          return zext_imm8(ins[7:0]);
            default:          return rdata;
        endcase
    endfunction

    function automatic logic is_legal(input logic [3:0] opc, input logic [3:0] ext);
        case (opc)
            4'b0000:                   return (ext == 4'b0101) || (ext == 4'b0110) || (ext == 4'b0111);
            4'b0101, 4'b0110, 4'b0111: return 1'b1;
            4'b1010:                   return (ext == 4'b0101) || (ext == 4'b0110);
            default:                   return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_IDLE: instr_ready = 1'b1;
            S_WB: begin
                done    = 1'b1;
                rf_we   = legal_q;
                illegal = ~legal_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        instr_d = instr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        legal_d = legal_q;
        res_d   = res_q;
        flg_d   = flg_q;
        psr_d   = psr_q;
        case (state_q)
            S_IDLE: if (instr_valid) instr_d = instr;
            S_READ: begin
                op_a_d  = rf_rdata_a;
                op_b_d  = operand_b(instr_q, rf_rdata_b);
                legal_d = is_legal(instr_q[15:12], instr_q[7:4]);
            end
            S_EXEC: begin
                res_d = alu_s;
                flg_d = alu_clfzn;
            end
            S_WB:    if (legal_q) psr_d = flg_q;
            default: ;
        endcase
`ifdef ALU_SEQ_PSR_LOAD_EN
        // A direct load beats the writeback flags on the same edge.
        if (psr_we) psr_d = psr_wdata;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            legal_q <= 1'b0;
            res_q   <= '0;
            flg_q   <= '0;
            psr_q   <= '0;
        end else begin
            instr_q <= instr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            legal_q <= legal_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            psr_q   <= psr_d;
        end
    end

    assign rf_raddr_a = instr_q[11:8];
    assign rf_raddr_b = instr_q[3:0];
    assign rf_waddr   = instr_q[11:8];
    assign rf_wdata   = res_q;
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_opcode = instr_q[15:12];
    assign alu_opext  = instr_q[7:4];
    assign alu_carry  = psr_q[FLAG_W-1];
    assign psr        = psr_q;

endmodule
